// File: rtl/button_debounce_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce_ctrl_pkg
//  Purpose  : Shared constants and helpers for the button debounce controller.
//             - INPUT_ON / INPUT_OFF : normalised channel levels
//             - clog2()             : counter width helper
//  Revision : 1.0  initial release
// ============================================================================
package button_debounce_ctrl_pkg;

    // Normalised level of a channel after polarity correction.
    localparam logic INPUT_ON  = 1'b1;
    localparam logic INPUT_OFF = 1'b0;

    // Ceiling log2, usable in constant expressions for counter widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : button_debounce_ctrl_pkg
`default_nettype wire

// File: rtl/button_debounce_ctrl_channel.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_channel
//  Purpose  : One debounced input channel. Tracks the accepted (stable) raw
//             level, requires DB consecutive ticks of difference before
//             accepting a change, and times HOLD ticks of active level.
//  Ports    : clk, rst          clock, asynchronous active-high reset
//             sync              synchronised raw level (polarity per DS)
//             tick              shared prescaler strobe
//             state             normalised debounced level (1 = active)
//             press_pulse       1-cycle pulse, channel became active
//             release_pulse     1-cycle pulse, channel became inactive
//             hold_pulse        1-cycle pulse, active for HOLD ticks
//  Revision : 1.0  initial release
// ============================================================================
module debounce_channel
    import button_debounce_ctrl_pkg::*;
#(
    parameter logic DS   = 1'b0,
    parameter int   DB   = 4,
    parameter int   HOLD = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    input  logic tick,
    output logic state,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int DW = clog2(DB + 1);
    localparam int HW = clog2(HOLD + 1);

    localparam logic [DW-1:0] c_DCNT_LAST = DW'(DB - 1);
    localparam logic [HW-1:0] c_HCNT_LAST = HW'(HOLD - 1);
    localparam logic [HW-1:0] c_HCNT_SAT  = HW'(HOLD);

    localparam logic [0:0] c_ST_STABLE = 1'b0;
    localparam logic [0:0] c_ST_PEND   = 1'b1;

    logic [0:0]    r_fsm;
    logic          r_stable;
    logic [DW-1:0] r_dcnt;
    logic [HW-1:0] r_hcnt;
    logic          r_press;
    logic          r_release;
    logic          r_hold;

    logic w_diff;
    logic w_active;
    logic w_accept;

    assign w_diff   = (sync != r_stable);
    assign w_active = (r_stable != DS);
    // Equality has priority over a coincident tick: w_diff gates acceptance.
    assign w_accept = (r_fsm == c_ST_PEND) && w_diff && tick && (r_dcnt == c_DCNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm     <= c_ST_STABLE;
            r_stable  <= DS;
            r_dcnt    <= '0;
            r_hcnt    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;

            case (r_fsm)
                c_ST_STABLE: begin
                    r_dcnt <= '0;
                    if (w_diff) begin
                        r_fsm <= c_ST_PEND;
                    end
                end
                c_ST_PEND: begin
                    if (!w_diff) begin
                        // Input bounced back: restart qualification from zero.
                        r_dcnt <= '0;
                        r_fsm  <= c_ST_STABLE;
                    end else if (tick) begin
                        if (r_dcnt == c_DCNT_LAST) begin
                            r_stable  <= sync;
                            r_dcnt    <= '0;
                            r_fsm     <= c_ST_STABLE;
                            r_press   <= (sync != DS);
                            r_release <= (sync == DS);
                        end else begin
                            r_dcnt <= r_dcnt + DW'(1);
                        end
                    end
                end
            endcase

            // Hold timer runs only while the accepted level is active; an
            // accepted release clears it on the same edge.
            if (!w_active || w_accept) begin
                r_hcnt <= '0;
            end else if (tick && (r_hcnt != c_HCNT_SAT)) begin
                if (r_hcnt == c_HCNT_LAST) begin
                    r_hcnt <= c_HCNT_SAT;
                    r_hold <= 1'b1;
                end else begin
                    r_hcnt <= r_hcnt + HW'(1);
                end
            end
        end
    end

    assign state         = w_active ? INPUT_ON : INPUT_OFF;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign hold_pulse    = r_hold;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/button_debounce_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce_ctrl
//  Purpose  : Debounce/event controller for IW raw buttons or switches.
//             Two-flop synchroniser per channel, one shared prescaler, and
//             one debounce_channel per input producing level and pulses.
//  Ports    : clk        system clock
//             rst        asynchronous reset, active-high
//             i_raw      [IW] raw asynchronous inputs (DS = idle level)
//             o_state    [IW] debounced level, 1 = active
//             o_press    [IW] 1-cycle pulse on activation
//             o_release  [IW] 1-cycle pulse on deactivation
//             o_hold     [IW] 1-cycle pulse after HOLD active ticks
//             o_tick          prescaler strobe
//  Revision : 1.0  initial release
// ============================================================================
module button_debounce_ctrl
    import button_debounce_ctrl_pkg::*;
#(
    parameter int   IW   = 1,
    parameter logic DS   = 1'b0,
    parameter int   PRE  = 1000,
    parameter int   DB   = 4,
    parameter int   HOLD = 250
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] i_raw,
    output logic [IW-1:0] o_state,
    output logic [IW-1:0] o_press,
    output logic [IW-1:0] o_release,
    output logic [IW-1:0] o_hold,
    output logic          o_tick
);

    localparam int PW = clog2(PRE);
    localparam logic [PW-1:0] c_PCNT_LAST = PW'(PRE - 1);

    logic [IW-1:0] r_sync1;
    logic [IW-1:0] r_sync2;
    logic [PW-1:0] r_pcnt;
    logic          w_tick;

    // Synchroniser flops reset to the idle level so no edge is seen out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= {IW{DS}};
            r_sync2 <= {IW{DS}};
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (r_pcnt == c_PCNT_LAST) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    assign w_tick = (r_pcnt == c_PCNT_LAST);
    assign o_tick = w_tick;

    for (genvar g = 0; g < IW; g++) begin : g_ch
        debounce_channel #(
            .DS   (DS),
            .DB   (DB),
            .HOLD (HOLD)
        ) u_channel (
            .clk           (clk),
            .rst           (rst),
            .sync          (r_sync2[g]),
            .tick          (w_tick),
            .state         (o_state[g]),
            .press_pulse   (o_press[g]),
            .release_pulse (o_release[g]),
            .hold_pulse    (o_hold[g])
        );
    end

endmodule : button_debounce_ctrl
`default_nettype wire

// File: tb/tb_button_debounce_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_button_debounce_ctrl
//  Purpose  : Directed bench for button_debounce_ctrl (PRE=4, DB=3, HOLD=5,
//             IW=2). Instance dut_h uses DS=0, dut_l uses DS=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_debounce_ctrl;

    localparam int IW   = 2;
    localparam int PRE  = 4;
    localparam int DB   = 3;
    localparam int HOLD = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] raw_h;
    logic [IW-1:0] raw_l;

    logic [IW-1:0] o_state_h, o_press_h, o_release_h, o_hold_h;
    logic          o_tick_h;
    logic [IW-1:0] o_state_l, o_press_l, o_release_l, o_hold_l;
    logic          o_tick_l;

    always #5 clk = ~clk;

    button_debounce_ctrl #(
        .IW(IW), .DS(1'b0), .PRE(PRE), .DB(DB), .HOLD(HOLD)
    ) dut_h (
        .clk       (clk),
        .rst       (rst),
        .i_raw     (raw_h),
        .o_state   (o_state_h),
        .o_press   (o_press_h),
        .o_release (o_release_h),
        .o_hold    (o_hold_h),
        .o_tick    (o_tick_h)
    );

    button_debounce_ctrl #(
        .IW(IW), .DS(1'b1), .PRE(PRE), .DB(DB), .HOLD(HOLD)
    ) dut_l (
        .clk       (clk),
        .rst       (rst),
        .i_raw     (raw_l),
        .o_state   (o_state_l),
        .o_press   (o_press_l),
        .o_release (o_release_l),
        .o_hold    (o_hold_l),
        .o_tick    (o_tick_l)
    );

    int n_vec = 0;
    int n_err = 0;

    int cnt_press_h[IW], cnt_rel_h[IW], cnt_hold_h[IW];
    int cnt_press_l[IW], cnt_rel_l[IW], cnt_hold_l[IW];
    int cnt_tick;
    int viol;

    // Advance one clock and sample on the falling edge, accumulating pulses.
    task automatic step();
        @(negedge clk);
        for (int c = 0; c < IW; c++) begin
            if (o_press_h[c])   cnt_press_h[c]++;
            if (o_release_h[c]) cnt_rel_h[c]++;
            if (o_hold_h[c])    cnt_hold_h[c]++;
            if (o_press_l[c])   cnt_press_l[c]++;
            if (o_release_l[c]) cnt_rel_l[c]++;
            if (o_hold_l[c])    cnt_hold_l[c]++;
        end
        if (o_tick_h) cnt_tick++;
        if (|(o_press_h & o_release_h) || |(o_press_h & o_hold_h) ||
            |(o_press_l & o_release_l) || |(o_press_l & o_hold_l)) viol++;
    endtask

    task automatic test_reset();
        int t0, ph, pl;
        rst   = 1'b1;
        raw_h = 2'b11;
        raw_l = 2'b00;
        repeat (3) step();
        n_vec++;
        if ({o_state_h, o_press_h, o_release_h, o_hold_h, o_tick_h} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outputs_h: got %b, want 0",
                     {o_state_h, o_press_h, o_release_h, o_hold_h, o_tick_h});
        end
        n_vec++;
        if ({o_state_l, o_press_l, o_release_l, o_hold_l, o_tick_l} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outputs_l: got %b, want 0",
                     {o_state_l, o_press_l, o_release_l, o_hold_l, o_tick_l});
        end
        raw_h = 2'b00;
        raw_l = 2'b11;
        step();
        rst = 1'b0;
        t0 = cnt_tick;
        ph = cnt_press_h[0] + cnt_press_h[1] + cnt_rel_h[0] + cnt_rel_h[1] + cnt_hold_h[0] + cnt_hold_h[1];
        pl = cnt_press_l[0] + cnt_press_l[1] + cnt_rel_l[0] + cnt_rel_l[1] + cnt_hold_l[0] + cnt_hold_l[1];
        repeat (200) step();
        n_vec++;
        if (cnt_tick - t0 != 50) begin
            n_err++;
            $display("FAIL tick_rate: got %0d ticks in 200 clk, want 50", cnt_tick - t0);
        end
        n_vec++;
        if (cnt_press_h[0] + cnt_press_h[1] + cnt_rel_h[0] + cnt_rel_h[1] + cnt_hold_h[0] + cnt_hold_h[1] != ph
            || o_state_h !== 2'b00) begin
            n_err++;
            $display("FAIL idle_no_events_h: state %b, pulses seen, want none", o_state_h);
        end
        n_vec++;
        if (cnt_press_l[0] + cnt_press_l[1] + cnt_rel_l[0] + cnt_rel_l[1] + cnt_hold_l[0] + cnt_hold_l[1] != pl
            || o_state_l !== 2'b00) begin
            n_err++;
            $display("FAIL idle_no_events_l: state %b, pulses seen, want none", o_state_l);
        end
    endtask

    task automatic test_clean_push();
        int n, p0, r0, h0, p1, r1, h1;
        p0 = cnt_press_h[0]; r0 = cnt_rel_h[0]; h0 = cnt_hold_h[0];
        p1 = cnt_press_h[1]; r1 = cnt_rel_h[1]; h1 = cnt_hold_h[1];
        raw_h[0] = 1'b1;
        n = 0;
        while (n < 40 && !o_press_h[0]) begin step(); n++; end
        n_vec++;
        if (n < 11 || n > 15) begin
            n_err++;
            $display("FAIL clean_press_latency: got %0d clk, want 11..15", n);
        end
        n_vec++;
        if (o_state_h !== 2'b01) begin
            n_err++;
            $display("FAIL clean_press_state: got %b, want 01", o_state_h);
        end
        repeat (40 - n) step();
        raw_h[0] = 1'b0;
        n = 0;
        while (n < 40 && !o_release_h[0]) begin step(); n++; end
        n_vec++;
        if (n < 11 || n > 15) begin
            n_err++;
            $display("FAIL clean_release_latency: got %0d clk, want 11..15", n);
        end
        n_vec++;
        if (o_state_h !== 2'b00) begin
            n_err++;
            $display("FAIL clean_release_state: got %b, want 00", o_state_h);
        end
        repeat (10) step();
        n_vec++;
        if (cnt_press_h[0] - p0 != 1 || cnt_rel_h[0] - r0 != 1) begin
            n_err++;
            $display("FAIL clean_pulse_count: press %0d release %0d, want 1 and 1",
                     cnt_press_h[0] - p0, cnt_rel_h[0] - r0);
        end
        n_vec++;
        if (cnt_hold_h[0] - h0 != 1) begin
            n_err++;
            $display("FAIL clean_hold_count: got %0d, want 1", cnt_hold_h[0] - h0);
        end
        n_vec++;
        if (cnt_press_h[1] != p1 || cnt_rel_h[1] != r1 || cnt_hold_h[1] != h1) begin
            n_err++;
            $display("FAIL clean_ch1_quiet: ch1 pulses %0d/%0d/%0d, want 0/0/0",
                     cnt_press_h[1] - p1, cnt_rel_h[1] - r1, cnt_hold_h[1] - h1);
        end
    endtask

    task automatic test_bounce();
        int n, p0, r0;
        p0 = cnt_press_h[0]; r0 = cnt_rel_h[0];
        for (int i = 0; i < 6; i++) begin
            raw_h[0] = (i % 2 == 0);
            repeat (5) step();
        end
        n_vec++;
        if (cnt_press_h[0] != p0 || cnt_rel_h[0] != r0 || o_state_h[0] !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_quiet: press %0d release %0d state %b, want 0 0 0",
                     cnt_press_h[0] - p0, cnt_rel_h[0] - r0, o_state_h[0]);
        end
        raw_h[0] = 1'b1;
        n = 0;
        while (n < 40 && !o_press_h[0]) begin step(); n++; end
        n_vec++;
        if (n < 11 || n > 15) begin
            n_err++;
            $display("FAIL bounce_press_latency: got %0d clk, want 11..15", n);
        end
        raw_h[0] = 1'b0;
        repeat (30) step();
        n_vec++;
        if (cnt_press_h[0] - p0 != 1 || cnt_rel_h[0] - r0 != 1) begin
            n_err++;
            $display("FAIL bounce_pulse_count: press %0d release %0d, want 1 and 1",
                     cnt_press_h[0] - p0, cnt_rel_h[0] - r0);
        end
    endtask

    task automatic test_hold();
        int n, m, h1;
        h1 = cnt_hold_h[1];
        raw_h[1] = 1'b1;
        n = 0;
        while (n < 40 && !o_press_h[1]) begin step(); n++; end
        n_vec++;
        if (n < 11 || n > 15) begin
            n_err++;
            $display("FAIL hold_press_latency: got %0d clk, want 11..15", n);
        end
        m = 0;
        while (m < 40 && !o_hold_h[1]) begin step(); m++; end
        n_vec++;
        if (m != 20) begin
            n_err++;
            $display("FAIL hold_delay: got %0d clk after press, want 20", m);
        end
        repeat (60 - n - m) step();
        n_vec++;
        if (cnt_hold_h[1] - h1 != 1) begin
            n_err++;
            $display("FAIL hold_once: got %0d hold pulses, want 1", cnt_hold_h[1] - h1);
        end
        raw_h[1] = 1'b0;
        n = 0;
        while (n < 40 && !o_release_h[1]) begin step(); n++; end
        n_vec++;
        if (n < 11 || n > 15) begin
            n_err++;
            $display("FAIL hold_release_latency: got %0d clk, want 11..15", n);
        end
        repeat (4) step();
        raw_h[1] = 1'b1;
        n = 0;
        while (n < 40 && !o_press_h[1]) begin step(); n++; end
        m = 0;
        while (m < 40 && !o_hold_h[1]) begin step(); m++; end
        n_vec++;
        if (m != 20) begin
            n_err++;
            $display("FAIL rehold_delay: got %0d clk after re-press, want 20", m);
        end
        raw_h[1] = 1'b0;
        repeat (20) step();
        n_vec++;
        if (cnt_hold_h[1] - h1 != 2 || o_state_h !== 2'b00) begin
            n_err++;
            $display("FAIL rehold_total: holds %0d state %b, want 2 and 00",
                     cnt_hold_h[1] - h1, o_state_h);
        end
    endtask

    task automatic test_active_low();
        int n, p0, r0;
        p0 = cnt_press_l[0]; r0 = cnt_rel_l[0];
        raw_l[0] = 1'b0;
        n = 0;
        while (n < 40 && !o_press_l[0]) begin step(); n++; end
        n_vec++;
        if (n < 11 || n > 15) begin
            n_err++;
            $display("FAIL ds1_press_latency: got %0d clk, want 11..15", n);
        end
        n_vec++;
        if (o_state_l !== 2'b01) begin
            n_err++;
            $display("FAIL ds1_press_state: got %b, want 01", o_state_l);
        end
        repeat (5) step();
        raw_l[0] = 1'b1;
        n = 0;
        while (n < 40 && !o_release_l[0]) begin step(); n++; end
        n_vec++;
        if (n < 11 || n > 15 || o_state_l !== 2'b00) begin
            n_err++;
            $display("FAIL ds1_release: latency %0d state %b, want 11..15 and 00", n, o_state_l);
        end
        repeat (5) step();
        n_vec++;
        if (cnt_press_l[0] - p0 != 1 || cnt_rel_l[0] - r0 != 1) begin
            n_err++;
            $display("FAIL ds1_pulse_count: press %0d release %0d, want 1 and 1",
                     cnt_press_l[0] - p0, cnt_rel_l[0] - r0);
        end
    endtask

    task automatic test_async_reset();
        int n, tot;
        raw_h[1] = 1'b1;
        n = 0;
        while (n < 40 && !o_press_h[1]) begin step(); n++; end
        repeat (8) step();
        raw_h[0] = 1'b1;
        repeat (6) step();
        n_vec++;
        if (o_state_h !== 2'b10) begin
            n_err++;
            $display("FAIL prereset_state: got %b, want 10", o_state_h);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({o_state_h, o_press_h, o_release_h, o_hold_h, o_tick_h} !== 9'b0) begin
            n_err++;
            $display("FAIL async_reset_outputs: got %b, want 0",
                     {o_state_h, o_press_h, o_release_h, o_hold_h, o_tick_h});
        end
        raw_h = 2'b00;
        repeat (3) step();
        rst = 1'b0;
        tot = cnt_press_h[0] + cnt_press_h[1] + cnt_rel_h[0] + cnt_rel_h[1] + cnt_hold_h[0] + cnt_hold_h[1];
        repeat (60) step();
        n_vec++;
        if (cnt_press_h[0] + cnt_press_h[1] + cnt_rel_h[0] + cnt_rel_h[1] + cnt_hold_h[0] + cnt_hold_h[1] != tot
            || o_state_h !== 2'b00) begin
            n_err++;
            $display("FAIL post_reset_quiet: state %b, pulses seen, want none", o_state_h);
        end
    endtask

    task automatic test_invariants();
        n_vec++;
        if (viol != 0) begin
            n_err++;
            $display("FAIL pulse_exclusion: got %0d conflicting cycles, want 0", viol);
        end
    endtask

    initial begin
        rst   = 1'b1;
        raw_h = 2'b00;
        raw_l = 2'b11;
        cnt_tick = 0;
        viol     = 0;
        for (int c = 0; c < IW; c++) begin
            cnt_press_h[c] = 0; cnt_rel_h[c] = 0; cnt_hold_h[c] = 0;
            cnt_press_l[c] = 0; cnt_rel_l[c] = 0; cnt_hold_l[c] = 0;
        end
        test_reset();
        test_clean_push();
        test_bounce();
        test_hold();
        test_active_low();
        test_async_reset();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_button_debounce_ctrl
`default_nettype wire
